// File: rtl/mem_ctrl_pkg.sv
// Shared types and default parameters for the memory stream sequencer.
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_RD_BASE = 0;
    localparam int unsigned DEF_WR_BASE = 64;
    localparam int unsigned DEF_MAX_LEN = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_stream_ctrl_if.sv
// Memory port plus operand/result handshakes between controller, memory and datapath.
interface mem_stream_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] mem_rd_adr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_adr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output mem_rd_adr, mem_wr_en, mem_wr_adr, mem_wr_data, out_valid, out_data, in_ready,
        input  mem_rd_data, out_ready, in_valid, in_data
    );

    modport slave (
        input  mem_rd_adr, mem_wr_en, mem_wr_adr, mem_wr_data, out_valid, out_data, in_ready,
        output mem_rd_data, out_ready, in_valid, in_data
    );
endinterface

// File: rtl/beat_counter.sv
// Up-counter of accepted beats with terminal compares and a base-offset memory address.
module beat_counter #(
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  limit_i,
    output logic [ADDR_W-1:0] adr_o,
    output logic              below_o,
    output logic              last_o
);
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Address wraps modulo 2^ADDR_W; the extra count bit only serves the compares.
    assign adr_o   = ADDR_W'(BASE) + cnt_q[ADDR_W-1:0];
    assign below_o = cnt_q < limit_i;
    assign last_o  = (cnt_q + CNT_W'(1)) == limit_i;
endmodule

// File: rtl/mem_stream_ctrl.sv
// Streams len words from RD_BASE to the datapath and writes the returned results at WR_BASE.
module mem_stream_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RD_BASE = DEF_RD_BASE,
    parameter int unsigned WR_BASE = DEF_WR_BASE,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    mem_stream_ctrl_if.master bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d, len_clamped;
    logic             cnt_clr, rd_beat, wr_beat;
    logic             rd_below, rd_last, wr_below, wr_last, wr_finishing;
    logic             streaming, active;
    logic [ADDR_W-1:0] rd_adr, wr_adr;
    logic [DATA_W-1:0] operand_word, result_word;

    assign len_clamped = ({1'b0, len} > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : {1'b0, len};

    assign streaming = (state_q == STREAM);
    assign active    = streaming || (state_q == DRAIN);

    assign bus.out_valid = streaming && rd_below;
    assign bus.in_ready  = active && wr_below;
    assign rd_beat       = bus.out_valid && bus.out_ready;
    assign wr_beat       = bus.in_valid && bus.in_ready;

    // Result side completes this cycle, either already full or taking its final beat now.
    assign wr_finishing = !wr_below || (wr_beat && wr_last);

    assign operand_word    = bus.mem_rd_data;
    assign result_word     = bus.in_data;
    assign bus.out_data    = operand_word;
    assign bus.mem_rd_adr  = rd_adr;
    assign bus.mem_wr_en   = wr_beat;
    assign bus.mem_wr_adr  = wr_adr;
    assign bus.mem_wr_data = result_word;

    assign busy = active;
    assign done = (state_q == DONE);

    beat_counter #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W),
        .BASE   (RD_BASE)
    ) u_rd_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .en_i    (rd_beat),
        .limit_i (len_q),
        .adr_o   (rd_adr),
        .below_o (rd_below),
        .last_o  (rd_last)
    );

    beat_counter #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W),
        .BASE   (WR_BASE)
    ) u_wr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .en_i    (wr_beat),
        .limit_i (len_q),
        .adr_o   (wr_adr),
        .below_o (wr_below),
        .last_o  (wr_last)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    len_d   = len_clamped;
                    state_d = (len_clamped == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (rd_beat && rd_last) begin
                    state_d = wr_finishing ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (wr_finishing) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end
endmodule
